// File: rtl/draw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : draw_pkg                                                       |
// | Purpose   : Shared types and constants for the sprite frame scheduler:     |
// |             FSM state encoding, sprite slot indices, clear-job selector.   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Slot map of the default six-slot configuration.
  localparam int OBJ_PLAYER = 0;
  localparam int OBJ_ENEMY1 = 1;
  localparam int OBJ_ENEMY2 = 2;
  localparam int OBJ_ENEMY3 = 3;
  localparam int OBJ_ENEMY4 = 4;
  localparam int OBJ_BULLET = 5;

  localparam int NUM_OBJ_DEFAULT = 6;
  // The clear job uses the first index past the last sprite slot.
  localparam int CLEAR_SEL = NUM_OBJ_DEFAULT;

endpackage
`default_nettype wire

// File: rtl/draw_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : draw_prio_enc                                                  |
// | Purpose   : Combinational lowest-set-bit encoder.                          |
// | Ports     : i_req [N-1:0] request mask                                     |
// |             o_idx [W-1:0] index of the lowest set bit (0 when none set)    |
// |             o_any         at least one bit of i_req is set                 |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module draw_prio_enc #(
  parameter int N = 6,
  parameter int W = 4
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = W'(i);
      end
    end
  end

  assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/draw_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : draw_sequencer                                                 |
// | Purpose   : Frame-level scheduler for the sprite renderer. Walks the       |
// |             active sprite slots in index order (optionally after a         |
// |             background clear) and hands one job at a time to the pixel    |
// |             drawer through a start/done handshake. Includes a per-job      |
// |             watchdog and a one-deep queue for early frame requests.        |
// | Ports     : clk, resetn (async, active low)                                |
// |             frame_start, obj_active[NUM_OBJ], draw_done          (in)      |
// |             draw_start, draw_sel[SEL_W], draw_clear, busy,                 |
// |             frame_done, timeout_err, overrun_err                 (out)     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_OBJ     = NUM_OBJ_DEFAULT,
  parameter int SEL_W       = 4,
  parameter bit CLEAR_EN    = 1'b1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_start,
  input  logic [NUM_OBJ-1:0] obj_active,
  input  logic               draw_done,
  output logic               draw_start,
  output logic [SEL_W-1:0]   draw_sel,
  output logic               draw_clear,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err,
  output logic               overrun_err
);

  // Watchdog counter is wide enough to hold TIMEOUT_CYC and saturates.
  localparam int                c_CNT_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT_CYC > 0) ? c_CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [SEL_W-1:0]   c_CLR_SEL  = SEL_W'(NUM_OBJ);

  state_t               state_q,   state_d;
  logic [NUM_OBJ-1:0]   pending_q, pending_d;
  logic [SEL_W-1:0]     sel_q,     sel_d;
  logic                 clear_q,   clear_d;
  logic                 busy_q,    busy_d;
  logic                 queued_q,  queued_d;
  logic [c_CNT_W-1:0]   wdog_q,    wdog_d;
  logic                 timeout_q, timeout_d;
  logic                 overrun_q, overrun_d;

  logic                 w_begin_frame;
  logic                 w_timeout_hit;
  logic [SEL_W-1:0]     w_scan_idx;
  logic                 w_scan_any;

  draw_prio_enc #(
    .N (NUM_OBJ),
    .W (SEL_W)
  ) u_prio_enc (
    .i_req (pending_q),
    .o_idx (w_scan_idx),
    .o_any (w_scan_any)
  );

  assign w_timeout_hit = (TIMEOUT_CYC != 0) && (wdog_q == c_CNT_LAST);

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    sel_d         = sel_q;
    clear_d       = clear_q;
    busy_d        = busy_q;
    queued_d      = queued_q;
    wdog_d        = wdog_q;
    timeout_d     = timeout_q;
    overrun_d     = overrun_q;
    w_begin_frame = 1'b0;

    // Requests arriving while a frame is in flight: keep one, drop the rest.
    if (frame_start && (state_q != IDLE)) begin
      if (queued_q) begin
        overrun_d = 1'b1;
      end else begin
        queued_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          w_begin_frame = 1'b1;
        end
      end
      SCAN: begin
        if (!w_scan_any) begin
          state_d = FINISH;
        end else begin
          sel_d   = w_scan_idx;
          clear_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (draw_done || w_timeout_hit) begin
          // A done in the timeout cycle still counts as a clean finish.
          if (!draw_done) begin
            timeout_d = 1'b1;
          end
          // The clear job index lies outside the mask, so it retires nothing.
          for (int i = 0; i < NUM_OBJ; i++) begin
            if (!clear_q && (sel_q == SEL_W'(i))) begin
              pending_d[i] = 1'b0;
            end
          end
          state_d = SCAN;
        end else if (wdog_q != {c_CNT_W{1'b1}}) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      FINISH: begin
        // A request landing in this very cycle is queued and consumed at once.
        if (queued_q || frame_start) begin
          queued_d      = 1'b0;
          w_begin_frame = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_begin_frame) begin
      pending_d = obj_active;
      busy_d    = 1'b1;
      if (CLEAR_EN) begin
        sel_d   = c_CLR_SEL;
        clear_d = 1'b1;
        state_d = ISSUE;
      end else begin
        state_d = SCAN;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      queued_q  <= 1'b0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      clear_q   <= clear_d;
      busy_q    <= busy_d;
      queued_q  <= queued_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign draw_start  = (state_q == ISSUE);
  assign frame_done  = (state_q == FINISH);
  assign draw_sel    = sel_q;
  assign draw_clear  = clear_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;
  assign overrun_err = overrun_q;

endmodule
`default_nettype wire
